// File: rtl/bio_pkg.sv
// Shared definitions for the parametrised board I/O controller:
// register indices and fixed bit positions within the 32-bit bus word.
package bio_pkg;

  typedef enum logic [1:0] {
    BIO_CTRL   = 2'd0,
    BIO_STATE  = 2'd1,
    BIO_STATUS = 2'd2,
    BIO_IEN    = 2'd3
  } bio_reg_e;

  localparam int FALL_OFS   = 16;
  localparam int SPI_EN_BIT = 31;

endpackage

// File: rtl/bio_debounce.sv
// One switch channel: two-flop synchroniser, tick-sampled debouncer and
// registered one-cycle rise/fall pulses of the debounced level.
module bio_debounce
  import bio_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic smp_q, smp_d;
  logic deb_q, deb_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // A new level is accepted only when two consecutive tick samples agree.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    smp_d   = smp_q;
    deb_d   = deb_q;
    if (tick) begin
      smp_d = sync2_q;
      if ((sync2_q == smp_q) && (sync2_q != deb_q)) begin
        deb_d = sync2_q;
      end
    end
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      smp_q   <= 1'b0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      smp_q   <= smp_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign deb  = deb_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/bio_ctrl.sv
// Board I/O controller on the internal I/O bus: LED/control register,
// debounced switch state, sticky W1C edge status and a maskable interrupt.
module bio_ctrl
  import bio_pkg::*;
#(
  parameter int NUM_SW     = 4,
  parameter int NUM_LED    = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               wt,
  output logic               irq,
  output logic               spi_en,
  input  logic [NUM_SW-1:0]  sw,
  output logic [NUM_LED-1:0] led,
  output logic               lcd_e,
  output logic               lcd_rw,
  output logic               lcd_rs,
  output logic               spi_ss_b,
  output logic               fpga_init_b
);

  logic [DEB_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [NUM_SW-1:0]  deb, rise, fall;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               spi_en_q, spi_en_d;
  logic [NUM_SW-1:0]  st_rise_q, st_rise_d;
  logic [NUM_SW-1:0]  st_fall_q, st_fall_d;
  logic [NUM_SW-1:0]  ien_rise_q, ien_rise_d;
  logic [NUM_SW-1:0]  ien_fall_q, ien_fall_d;
  logic               irq_q, irq_d;
  logic               wr_en;
  bio_reg_e           reg_sel;
  logic               unused_data;

  assign tick    = (cnt_q == DEB_W'(DEB_CYCLES - 1));
  assign cnt_d   = tick ? '0 : cnt_q + DEB_W'(1);
  assign wr_en   = en & wr;
  assign reg_sel = bio_reg_e'(addr);

  // Several data_in bits have no storage behind them.
  assign unused_data = ^data_in;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
    bio_debounce u_deb (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (sw[g]),
      .deb  (deb[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  // Edge pulses are OR-ed in after the W1C so a same-cycle set wins.
  always_comb begin
    led_d      = led_q;
    spi_en_d   = spi_en_q;
    st_rise_d  = st_rise_q;
    st_fall_d  = st_fall_q;
    ien_rise_d = ien_rise_q;
    ien_fall_d = ien_fall_q;
    if (wr_en) begin
      case (reg_sel)
        BIO_CTRL: begin
          led_d    = data_in[NUM_LED-1:0];
          spi_en_d = data_in[SPI_EN_BIT];
        end
        BIO_STATE: begin
        end
        BIO_STATUS: begin
          st_rise_d = st_rise_q & ~data_in[NUM_SW-1:0];
          st_fall_d = st_fall_q & ~data_in[FALL_OFS +: NUM_SW];
        end
        BIO_IEN: begin
          ien_rise_d = data_in[NUM_SW-1:0];
          ien_fall_d = data_in[FALL_OFS +: NUM_SW];
        end
      endcase
    end
    st_rise_d = st_rise_d | rise;
    st_fall_d = st_fall_d | fall;
    irq_d     = (|(st_rise_q & ien_rise_q)) | (|(st_fall_q & ien_fall_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      led_q      <= '0;
      spi_en_q   <= 1'b0;
      st_rise_q  <= '0;
      st_fall_q  <= '0;
      ien_rise_q <= '0;
      ien_fall_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      spi_en_q   <= spi_en_d;
      st_rise_q  <= st_rise_d;
      st_fall_q  <= st_fall_d;
      ien_rise_q <= ien_rise_d;
      ien_fall_q <= ien_fall_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    data_out = '0;
    case (reg_sel)
      BIO_CTRL: begin
        data_out[NUM_LED-1:0]  = led_q;
        data_out[SPI_EN_BIT]   = spi_en_q;
      end
      BIO_STATE: begin
        data_out[NUM_SW-1:0]   = deb;
      end
      BIO_STATUS: begin
        data_out[NUM_SW-1:0]          = st_rise_q;
        data_out[FALL_OFS +: NUM_SW]  = st_fall_q;
      end
      BIO_IEN: begin
        data_out[NUM_SW-1:0]          = ien_rise_q;
        data_out[FALL_OFS +: NUM_SW]  = ien_fall_q;
      end
    endcase
  end

  assign led         = led_q;
  assign spi_en      = spi_en_q;
  assign irq         = irq_q;
  assign wt          = 1'b0;
  assign lcd_e       = 1'b0;
  assign lcd_rw      = 1'b0;
  assign lcd_rs      = 1'b0;
  assign spi_ss_b    = 1'b1;
  assign fpga_init_b = 1'b0;

endmodule

// File: tb/tb_bio_ctrl.sv
// Bench for bio_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed register values.
module tb_bio_ctrl;

  localparam int NSW = 4;
  localparam int NLED = 8;
  localparam int DEB = 8;
  localparam bit [31:0] CTRL_MASK = 32'h8000_00FF;
  localparam bit [31:0] EV_MASK   = 32'h000F_000F;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en = 1'b0;
  logic            wr = 1'b0;
  logic [1:0]      addr = 2'd0;
  logic [31:0]     data_in = 32'd0;
  logic [31:0]     data_out;
  logic            wt, irq, spi_en;
  logic [NSW-1:0]  sw = '0;
  logic [NLED-1:0] led;
  logic            lcd_e, lcd_rw, lcd_rs, spi_ss_b, fpga_init_b;

  int total = 0;
  int bad = 0;

  bio_ctrl #(
    .NUM_SW    (NSW),
    .NUM_LED   (NLED),
    .DEB_CYCLES(DEB),
    .DEB_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .wt         (wt),
    .irq        (irq),
    .spi_en     (spi_en),
    .sw         (sw),
    .led        (led),
    .lcd_e      (lcd_e),
    .lcd_rw     (lcd_rw),
    .lcd_rs     (lcd_rs),
    .spi_ss_b   (spi_ss_b),
    .fpga_init_b(fpga_init_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: sw seen two clocks late, sampled every DEB-th clock,
  // level accepted on two equal samples, status one clock later, irq one more.
  bit [NSW-1:0] m_h1, m_h2, m_smp, m_deb, m_rp, m_fp, m_chg;
  bit [31:0]    m_ctrl, m_status, m_ien;
  bit           m_irq;
  int           m_phase;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_h1 = '0; m_h2 = '0; m_smp = '0; m_deb = '0; m_rp = '0; m_fp = '0;
      m_ctrl = '0; m_status = '0; m_ien = '0; m_irq = 1'b0; m_phase = 0;
    end else begin
      m_irq = ((m_status & m_ien) != 0);
      if (en && wr && addr == 2'd2) m_status = m_status & ~(data_in & EV_MASK);
      m_status = m_status | (32'(m_fp) << 16) | 32'(m_rp);
      if (en && wr && addr == 2'd0) m_ctrl = data_in & CTRL_MASK;
      if (en && wr && addr == 2'd3) m_ien = data_in & EV_MASK;
      m_rp = '0;
      m_fp = '0;
      if (m_phase == DEB - 1) begin
        m_chg = ~(m_h2 ^ m_smp) & (m_h2 ^ m_deb);
        m_rp  = m_chg & m_h2;
        m_fp  = m_chg & ~m_h2;
        m_deb = m_deb ^ m_chg;
        m_smp = m_h2;
      end
      m_h2 = m_h1;
      m_h1 = sw;
      m_phase = (m_phase + 1) % DEB;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_ctrl;
      2'd1:    return 32'(m_deb);
      2'd2:    return m_status;
      default: return m_ien;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = we; addr = a; data_in = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0; data_in = 32'd0;
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    checkOutput(name, data_out, exp);
  endtask

  // Compare process against the model on every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      checkOutput("cmp_rdata", data_out, model_read(addr));
      checkOutput("cmp_led", 32'(led), 32'(m_ctrl[NLED-1:0]));
      checkOutput("cmp_spi_en", 32'(spi_en), 32'(m_ctrl[31]));
      checkOutput("cmp_irq", 32'(irq), 32'(m_irq));
      checkOutput("cmp_ties", 32'({wt, lcd_e, lcd_rw, lcd_rs, spi_ss_b, fpga_init_b}), 32'h02);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) readCheck($sformatf("reset_read%0d", i), 2'(i), 32'h0);

    applyStimulus(1'b1, 2'd0, 32'h8000_00A5);
    #1;
    checkOutput("ctrl_read", data_out, 32'h8000_00A5);
    checkOutput("ctrl_led", 32'(led), 32'h0000_00A5);
    checkOutput("ctrl_spi_en", 32'(spi_en), 32'h1);

    @(negedge clk);
    addr = 2'd1;
    sw[0] = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
      if (data_out == 32'h1) seen = 1'b1;
    end
    checkOutput($sformatf("deb_latency_in_range(lat=%0d)", lat),
                32'(lat >= DEB + 2 && lat <= 2 * DEB + 2), 32'h1);
    repeat (2) @(negedge clk);
    readCheck("status_rise0", 2'd2, 32'h0000_0001);

    for (int k = 0; k < 2 * DEB; k++) begin
      @(negedge clk);
      if (m_phase == 1) break;
    end
    sw[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw[1] = 1'b0;
    addr = 2'd2;
    repeat (40) begin
      @(negedge clk);
      #1;
      checkOutput("glitch_status", data_out & 32'h0002_0002, 32'h0);
    end
    readCheck("glitch_state", 2'd1, 32'h0000_0001);

    applyStimulus(1'b1, 2'd3, 32'h0001_0000);
    sw[0] = 1'b0;
    addr = 2'd2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (data_out[16]) break;
    end
    checkOutput("status_fall0", data_out, 32'h0001_0001);
    checkOutput("irq_before_rise", 32'(irq), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("irq_rise", 32'(irq), 32'h1);

    applyStimulus(1'b1, 2'd2, 32'h0001_0000);
    #1;
    checkOutput("w1c_status", data_out, 32'h0000_0001);
    checkOutput("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("irq_drop", 32'(irq), 32'h0);

    sw[2] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_rp[2]) break;
    end
    en = 1'b1; wr = 1'b1; addr = 2'd2; data_in = 32'h0000_0004;
    @(negedge clk);
    en = 1'b0; wr = 1'b0; data_in = 32'd0;
    #1;
    checkOutput("race_status", data_out, 32'h0000_0005);

    applyStimulus(1'b1, 2'd3, 32'h0000_0001);
    @(negedge clk);
    #1;
    checkOutput("irq_pre_reset", 32'(irq), 32'h1);
    sw[3] = 1'b1;
    repeat (12) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_spi_en", 32'(spi_en), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      checkOutput($sformatf("rst_read%0d", i), data_out, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
